// File: rtl/landing_lights_param.sv
// rtl/landing_lights_param.sv - parametrised runway landing-light sequencer
//
// Purpose: drives N_LIGHTS lamps through one of four display patterns.
// An internal prescaler produces one pattern STEP every TICK_DIV enabled
// clock edges. Everything runs on clk; the prescaler output is an enable,
// not a divided clock.
//
// Ports:
//   clk     in   1         system clock
//   reset   in   1         asynchronous, active-high reset
//   enable  in   1         1 = prescaler runs; 0 = prescaler and lights freeze
//   mode    in   2         00 calm, 01 wind-right, 10 wind-left, 11 hazard
//                          (asynchronous board-switch source)
//   lights  out  N_LIGHTS  lamp drive; bit N_LIGHTS-1 is the leftmost lamp
//   tick    out  1         one-cycle pulse in the cycle after each STEP
module landing_lights_param #(
  parameter int N_LIGHTS = 5,
  parameter int TICK_DIV = 33554432
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic [N_LIGHTS-1:0] lights,
  output logic                tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  localparam logic [N_LIGHTS-1:0] LSB_ONLY = N_LIGHTS'(1);
  localparam logic [N_LIGHTS-1:0] MSB_ONLY = N_LIGHTS'(1) << (N_LIGHTS - 1);
  localparam logic [N_LIGHTS-1:0] CENTER   = N_LIGHTS'(1) << (N_LIGHTS / 2);
  localparam logic [N_LIGHTS-1:0] OUTER    = MSB_ONLY | LSB_ONLY;
  localparam logic [N_LIGHTS-1:0] ALL      = '1;

  // The centre lamp must be unique, so an even or tiny lamp count is rejected.
  if (N_LIGHTS < 3 || (N_LIGHTS % 2) == 0) begin : g_bad_n_lights
    $error("landing_lights_param: N_LIGHTS must be odd and >= 3");
  end
  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("landing_lights_param: TICK_DIV must be >= 1");
  end

  typedef enum logic [1:0] {
    MODE_CALM   = 2'b00,
    MODE_RIGHT  = 2'b01,
    MODE_LEFT   = 2'b10,
    MODE_HAZARD = 2'b11
  } mode_e;

  logic [1:0]          sync1_q, mode_s_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d, next_lights;
  logic                tick_q, tick_d;
  logic                step;
  logic                one_hot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 2'b00;
      mode_s_q <= 2'b00;
      cnt_q    <= '0;
      lights_q <= CENTER;
      tick_q   <= 1'b0;
    end else begin
      // The synchroniser runs regardless of enable so a mode change made
      // while frozen is already settled when counting resumes.
      sync1_q  <= mode;
      mode_s_q <= sync1_q;
      cnt_q    <= cnt_d;
      lights_q <= lights_d;
      tick_q   <= tick_d;
    end
  end

  assign step    = enable && (cnt_q == CNT_MAX);
  assign one_hot = (lights_q != '0) && ((lights_q & (lights_q - N_LIGHTS'(1))) == '0);

  // Every possible lights value maps to a legal pattern, so a corrupted
  // value is cleared at the next STEP.
  always_comb begin
    next_lights = lights_q;
    case (mode_e'(mode_s_q))
      MODE_CALM:   next_lights = (lights_q == CENTER) ? OUTER : CENTER;
      MODE_RIGHT:  next_lights = one_hot ? {lights_q[0], lights_q[N_LIGHTS-1:1]} : MSB_ONLY;
      MODE_LEFT:   next_lights = one_hot ? {lights_q[N_LIGHTS-2:0], lights_q[N_LIGHTS-1]} : LSB_ONLY;
      MODE_HAZARD: next_lights = (lights_q == ALL) ? '0 : ALL;
      default:     next_lights = CENTER;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    lights_d = lights_q;
    tick_d   = step;
    if (enable) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
    if (step) begin
      lights_d = next_lights;
    end
  end

  assign lights = lights_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_landing_lights_param.sv
// tb/tb_landing_lights_param.sv - directed bench for landing_lights_param
module tb_landing_lights_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] mode;
  logic [4:0] lights4, lights1;
  logic       tick4, tick1;

  int n_checks = 0;
  int n_pass   = 0;

  landing_lights_param #(.N_LIGHTS(5), .TICK_DIV(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .lights (lights4),
    .tick   (tick4)
  );

  landing_lights_param #(.N_LIGHTS(5), .TICK_DIV(1)) dut_div1 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .lights (lights1),
    .tick   (tick1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    mode   = 2'b00;
    #2;
    check("rst_lights", lights4, 5'b00100);
    check("rst_tick", tick4, 1'b0);
    check("rst_lights_div1", lights1, 5'b00100);
    edges(2);
    check("rst_hold_lights", lights4, 5'b00100);
    reset = 1'b0;

    // calm: first STEP on the 4th edge, tick in the following cycle
    edges(3);
    check("calm_pre_step", lights4, 5'b00100);
    check("calm_pre_tick", tick4, 1'b0);
    edges(1);
    check("calm_s1", lights4, 5'b10001);
    check("calm_s1_tick", tick4, 1'b1);
    edges(1);
    check("calm_tick_drop", tick4, 1'b0);
    edges(3);
    check("calm_s2", lights4, 5'b00100);
    check("calm_s2_tick", tick4, 1'b1);
    edges(4);
    check("calm_s3", lights4, 5'b10001);
    edges(4);
    check("calm_s4", lights4, 5'b00100);

    // wind-right from centre
    mode = 2'b01;
    edges(4); check("right_1", lights4, 5'b00010);
    edges(4); check("right_2", lights4, 5'b00001);
    edges(4); check("right_3", lights4, 5'b10000);
    edges(4); check("right_4", lights4, 5'b01000);

    // back to calm to reach 10001, then wind-left
    mode = 2'b00;
    edges(4); check("calm_recenter", lights4, 5'b00100);
    edges(4); check("calm_outer", lights4, 5'b10001);
    mode = 2'b10;
    edges(4); check("left_load", lights4, 5'b00001);
    edges(4); check("left_1", lights4, 5'b00010);
    edges(4); check("left_2", lights4, 5'b00100);
    edges(4); check("left_3", lights4, 5'b01000);
    edges(4); check("left_4", lights4, 5'b10000);
    edges(4); check("left_wrap", lights4, 5'b00001);

    // hazard from centre
    mode = 2'b00;
    edges(4); check("calm_from_left", lights4, 5'b00100);
    mode = 2'b11;
    edges(4); check("hazard_1", lights4, 5'b11111);
    edges(4); check("hazard_2", lights4, 5'b00000);
    edges(4); check("hazard_3", lights4, 5'b11111);
    mode = 2'b00;
    edges(4); check("hazard_to_calm", lights4, 5'b00100);

    // mode change one cycle before a STEP is missed by that STEP
    edges(3);
    mode = 2'b11;
    edges(1); check("late_mode_step", lights4, 5'b10001);
    edges(4); check("late_mode_next", lights4, 5'b11111);
    // mode change three cycles before a STEP is seen at that STEP
    edges(1);
    mode = 2'b00;
    edges(3); check("early_mode_step", lights4, 5'b00100);

    // freeze with cnt=2
    edges(2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      check($sformatf("freeze_lights_%0d", i), lights4, 5'b00100);
      check($sformatf("freeze_tick_%0d", i), tick4, 1'b0);
    end
    enable = 1'b1;
    edges(1);
    check("resume_1", lights4, 5'b00100);
    check("resume_1_tick", tick4, 1'b0);
    edges(1);
    check("resume_step", lights4, 5'b10001);
    check("resume_tick", tick4, 1'b1);

    // async reset between edges
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_lights", lights4, 5'b00100);
    check("async_rst_tick", tick4, 1'b0);
    #2;
    reset = 1'b0;
    edges(3);
    check("post_rst_pre", lights4, 5'b00100);
    edges(1);
    check("post_rst_step", lights4, 5'b10001);

    // TICK_DIV=1 instance: fresh reset, calm toggles every edge
    #2;
    reset = 1'b1;
    #2;
    check("div1_rst", lights1, 5'b00100);
    reset = 1'b0;
    edges(1);
    check("div1_s1", lights1, 5'b10001);
    check("div1_t1", tick1, 1'b1);
    edges(1);
    check("div1_s2", lights1, 5'b00100);
    check("div1_t2", tick1, 1'b1);
    edges(1);
    check("div1_s3", lights1, 5'b10001);
    check("div1_t3", tick1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
